// File: rtl/octave_ctrl.sv
// Octave selector: two debounced-by-edge buttons step a bounded octave index.
// Define OCTAVE_AUTOREPEAT_EN to build the held-button auto-repeat FSM.
module octave_ctrl #(
    parameter int NUM_OCT       = 4,
    parameter int RESET_OCT     = 0,
    parameter int WRAP_EN       = 0,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    localparam int OCT_W        = (NUM_OCT > 2) ? $clog2(NUM_OCT) : 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             oct_up,
    input  logic             oct_down,
    output logic [OCT_W-1:0] oct_switch,
    output logic             at_min,
    output logic             at_max,
    output logic             oct_changed
);

    localparam logic [OCT_W-1:0] MAX_OCT = OCT_W'(NUM_OCT - 1);
    localparam logic [OCT_W-1:0] RST_OCT = OCT_W'(RESET_OCT);

    // bit 0 = metastable stage, bit 1 = synchronised level, bit 2 = history
    logic [2:0]       up_sr_r;
    logic [2:0]       dn_sr_r;
    logic             up_press_s;
    logic             dn_press_s;
    logic             step_up_s;
    logic             step_dn_s;
    logic [OCT_W-1:0] oct_next_s;
    logic             chg_next_s;

    // Button synchronisers plus history flop for press detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            up_sr_r <= 3'b000;
            dn_sr_r <= 3'b000;
        end else begin
            up_sr_r <= {up_sr_r[1:0], oct_up};
            dn_sr_r <= {dn_sr_r[1:0], oct_down};
        end
    end

    assign up_press_s = up_sr_r[1] & ~up_sr_r[2];
    assign dn_press_s = dn_sr_r[1] & ~dn_sr_r[2];

`ifdef OCTAVE_AUTOREPEAT_EN
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             dir_up_r;
    logic             dir_next_s;
    logic             abort_s;
    logic             hold_done_s;
    logic             rep_done_s;

    // The held sequence ends when the active button drops or the other one rises.
    assign abort_s     = dir_up_r ? (~up_sr_r[1] | dn_sr_r[1]) : (~dn_sr_r[1] | up_sr_r[1]);
    assign hold_done_s = (cnt_r == CNT_W'(HOLD_CYCLES - 1));
    assign rep_done_s  = (cnt_r == CNT_W'(REPEAT_CYCLES - 1));

    // Repeat FSM state, cycle counter and active direction.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            dir_up_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            dir_up_r <= dir_next_s;
        end
    end

    // Repeat FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = (up_press_s ^ dn_press_s) ? HOLD : IDLE;
            HOLD: begin
                if (abort_s)          state_next_s = IDLE;
                else if (hold_done_s) state_next_s = REPEAT;
                else                  state_next_s = HOLD;
            end
            REPEAT:  state_next_s = abort_s ? IDLE : REPEAT;
            default: state_next_s = IDLE;
        endcase
    end

    // Repeat FSM outputs: step requests, counter and direction updates.
    always_comb begin
        step_up_s  = 1'b0;
        step_dn_s  = 1'b0;
        cnt_next_s = cnt_r;
        dir_next_s = dir_up_r;
        case (state_r)
            IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (up_press_s && !dn_press_s) begin
                    step_up_s  = 1'b1;
                    dir_next_s = 1'b1;
                end else if (dn_press_s && !up_press_s) begin
                    step_dn_s  = 1'b1;
                    dir_next_s = 1'b0;
                end else begin
                    dir_next_s = dir_up_r;
                end
            end
            HOLD, REPEAT: begin
                if (abort_s) begin
                    cnt_next_s = {CNT_W{1'b0}};
                end else if ((state_r == HOLD) ? hold_done_s : rep_done_s) begin
                    cnt_next_s = {CNT_W{1'b0}};
                    step_up_s  = dir_up_r;
                    step_dn_s  = ~dir_up_r;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            default: cnt_next_s = {CNT_W{1'b0}};
        endcase
    end
`else
    assign step_up_s = up_press_s & ~dn_press_s;
    assign step_dn_s = dn_press_s & ~up_press_s;
`endif

    // Bounded step: saturate or wrap at the ends, never exceed NUM_OCT-1.
    always_comb begin
        oct_next_s = oct_switch;
        chg_next_s = 1'b0;
        if (step_up_s) begin
            if (oct_switch >= MAX_OCT) begin
                if (WRAP_EN != 0) begin
                    oct_next_s = {OCT_W{1'b0}};
                    chg_next_s = 1'b1;
                end else begin
                    oct_next_s = MAX_OCT;
                end
            end else begin
                oct_next_s = oct_switch + OCT_W'(1);
                chg_next_s = 1'b1;
            end
        end else if (step_dn_s) begin
            if (oct_switch == {OCT_W{1'b0}}) begin
                if (WRAP_EN != 0) begin
                    oct_next_s = MAX_OCT;
                    chg_next_s = 1'b1;
                end else begin
                    oct_next_s = {OCT_W{1'b0}};
                end
            end else begin
                oct_next_s = oct_switch - OCT_W'(1);
                chg_next_s = 1'b1;
            end
        end else begin
            oct_next_s = oct_switch;
        end
    end

    // Registered octave index and its status flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            oct_switch  <= RST_OCT;
            at_min      <= (RESET_OCT == 0);
            at_max      <= (RESET_OCT == NUM_OCT - 1);
            oct_changed <= 1'b0;
        end else begin
            oct_switch  <= oct_next_s;
            at_min      <= (oct_next_s == {OCT_W{1'b0}});
            at_max      <= (oct_next_s == MAX_OCT);
            oct_changed <= chg_next_s;
        end
    end

endmodule
